burst_ram_arbiter: RTL

//  Parametrised N-client arbiter sharing one BurstRAM controller among cache clients (icache, dcache, DMA, ...).

---
 rtl/burst_ram_arbiter_pkg.sv | 14 +
 rtl/burst_ram_arbiter_if.sv | 37 +++
 rtl/burst_ram_arbiter_rr_priority_picker.sv | 31 +++
 rtl/burst_ram_arbiter.sv | 96 +++++++++
 4 files changed

// File: rtl/burst_ram_arbiter_pkg.sv
// burst_ram_pkg: shared arbiter state encodings, BurstRAM command codes and slice helper
// Exports: arb_state_t (one-hot IDLE/GRANT/DRAIN), CMD_READ/CMD_WRITE, slice_lo()
package burst_ram_pkg;
  typedef enum logic [2:0] {
    ARB_IDLE  = 3'b001,
    ARB_GRANT = 3'b010,
    ARB_DRAIN = 3'b100
  } arb_state_t;
  localparam logic CMD_READ = 1'b0;
  localparam logic CMD_WRITE = 1'b1;
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction
endpackage

// File: rtl/burst_ram_arbiter_if.sv
// burst_ram_arbiter_if: client-side and BurstRAM-side bus shared through the arbiter
// slave: arbiter view (client requests and RAM status in; grant/valid/busy and br_* out)
// master: client/RAM view; br_rd_data is a plain fan-out the arbiter never touches
interface burst_ram_arbiter_if #(
  parameter int NUM_CLIENTS = 2,
  parameter int RAM_DEPTH_BITWIDTH = 4,
  parameter int RAM_BURST_DATA_BITWIDTH = 64
);
  localparam int N = NUM_CLIENTS;
  localparam int D = RAM_DEPTH_BITWIDTH;
  localparam int B = RAM_BURST_DATA_BITWIDTH;
  logic [N-1:0] c_req;
  logic [N-1:0] c_cmd;
  logic [N-1:0] c_cmd_en;
  logic [N*D-1:0] c_addr;
  logic [N*B-1:0] c_wr_data;
  logic [N*B/8-1:0] c_data_mask;
  logic [N-1:0] c_grant;
  logic [N-1:0] c_rd_data_valid;
  logic [N-1:0] c_busy;
  logic br_cmd;
  logic br_cmd_en;
  logic [D-1:0] br_addr;
  logic [B-1:0] br_wr_data;
  logic [B/8-1:0] br_data_mask;
  logic [B-1:0] br_rd_data;
  logic br_rd_data_valid;
  logic br_busy;
  modport slave (
    input c_req, c_cmd, c_cmd_en, c_addr, c_wr_data, c_data_mask, br_rd_data_valid, br_busy,
    output c_grant, c_rd_data_valid, c_busy, br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
  );
  modport master (
    output c_req, c_cmd, c_cmd_en, c_addr, c_wr_data, c_data_mask, br_rd_data, br_rd_data_valid, br_busy,
    input c_grant, c_rd_data_valid, c_busy, br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
  );
endinterface

// File: rtl/burst_ram_arbiter_rr_priority_picker.sv
// rr_priority_picker: combinational winner select, round-robin from ptr or fixed lowest-index
// req: request vector; ptr: rr start index; rr: 1 round-robin, 0 fixed
// win: one-hot winner; idx: winner index; any: some request present
module rr_priority_picker #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          rr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx,
  output logic          any
);
  int j;
  // scan from the far end so the nearest candidate overwrites and wins
  always_comb begin
    win = '0;
    idx = '0;
    j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = rr ? (int'(ptr) + k) % N : k;
      if (req[IW'(j)]) begin
        win = '0;
        win[IW'(j)] = 1'b1;
        idx = IW'(j);
      end
    end
  end
  assign any = |req;
endmodule

// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter: whole-transaction arbiter sharing one BurstRAM controller among N clients
// clk, rst: clock and synchronous active-high reset
// bus (slave): client req/cmd/addr/data in, grant/rd_valid/busy out, br_* muxed from the owner
module burst_ram_arbiter
  import burst_ram_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int RAM_DEPTH_BITWIDTH = 4,
  parameter int RAM_BURST_DATA_BITWIDTH = 64,
  parameter int ROUND_ROBIN = 1
) (
  input logic clk,
  input logic rst,
  burst_ram_arbiter_if.slave bus
);
  localparam int N = NUM_CLIENTS;
  localparam int D = RAM_DEPTH_BITWIDTH;
  localparam int B = RAM_BURST_DATA_BITWIDTH;
  localparam int M = B / 8;
  localparam int IW = $clog2(N);
  arb_state_t state, state_n;
  logic [N-1:0] grant, grant_n, win;
  logic [IW-1:0] owner, owner_n, ptr, ptr_n, widx;
  logic any;
  logic cmd, cmd_en;
  logic [D-1:0] addr;
  logic [B-1:0] wr_data;
  logic [M-1:0] mask;
  rr_priority_picker #(.N(N)) u_pick (
    .req(bus.c_req),
    .ptr(ptr),
    .rr(ROUND_ROBIN != 0),
    .win(win),
    .idx(widx),
    .any(any)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      grant <= '0;
      owner <= '0;
      ptr <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      owner <= owner_n;
      ptr <= ptr_n;
    end
  end
  always_comb begin
    state_n = state;
    grant_n = grant;
    owner_n = owner;
    ptr_n = ptr;
    case (state)
      ARB_IDLE: if (any && !bus.br_busy) begin
        state_n = ARB_GRANT;
        grant_n = win;
        owner_n = widx;
      end
      ARB_GRANT: if (!(|(grant & bus.c_req))) state_n = ARB_DRAIN;
      ARB_DRAIN: if (!bus.br_busy && !bus.br_rd_data_valid) begin
        state_n = ARB_IDLE;
        grant_n = '0;
        ptr_n = owner == IW'(N - 1) ? '0 : owner + 1'b1;
      end
      default: begin
        state_n = ARB_IDLE;
        grant_n = '0;
      end
    endcase
  end
  // grant is one-hot or zero, so an OR-free select by grant bit yields 0 when idle
  always_comb begin
    cmd = CMD_READ;
    cmd_en = 1'b0;
    addr = '0;
    wr_data = '0;
    mask = '0;
    for (int i = 0; i < N; i++) if (grant[i]) begin
      cmd = bus.c_cmd[i];
      cmd_en = bus.c_req[i] && bus.c_cmd_en[i];
      addr = bus.c_addr[slice_lo(i, D) +: D];
      wr_data = bus.c_wr_data[slice_lo(i, B) +: B];
      mask = bus.c_data_mask[slice_lo(i, M) +: M];
    end
  end
  assign bus.c_grant = grant;
  assign bus.c_rd_data_valid = grant & {N{bus.br_rd_data_valid && !rst}};
  assign bus.c_busy = ~grant | {N{bus.br_busy}};
  assign bus.br_cmd = cmd;
  assign bus.br_cmd_en = state == ARB_GRANT && cmd_en;
  assign bus.br_addr = addr;
  assign bus.br_wr_data = wr_data;
  assign bus.br_data_mask = mask;
endmodule
